global_branch_predictor: RTL and testbench

Gshare-style global branch predictor that sits beside fetch and directly upstream of the decode-stage branch comparator. It supplies a taken/not-taken prediction for the current fetch PC. It consumes the resolved beq/bne outcome from decode to train a pattern history table (PHT) of 2-bit saturating counters and a global history register (GHR). It also flags mispredictions so the pipeline can flush, and keeps branch and mispredict statistics.

---
 rtl/global_branch_predictor_pkg.sv | 22 ++
 rtl/global_branch_predictor_sat_counter2.sv | 29 ++
 rtl/global_branch_predictor.sv | 112 +++++++++++
 tb/tb_global_branch_predictor.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/global_branch_predictor_pkg.sv
// +----------------------------------------------------------------------+
// | Module   : global_branch_predictor_pkg                               |
// | Brief    : Counter encodings and FSM states for the gshare predictor |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

package global_branch_predictor_pkg;

    localparam logic [1:0] c_SNT = 2'b00;
    localparam logic [1:0] c_WNT = 2'b01;
    localparam logic [1:0] c_WT  = 2'b10;
    localparam logic [1:0] c_ST  = 2'b11;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/global_branch_predictor_sat_counter2.sv
// +----------------------------------------------------------------------+
// | Module   : sat_counter2                                              |
// | Brief    : Next value of a 2-bit saturating counter toward 'taken'   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module sat_counter2
    import global_branch_predictor_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       taken,
    output logic [1:0] nxt
);

    always_comb begin
        nxt = cur;
        case (cur)
            c_SNT:   nxt = taken ? c_WNT : c_SNT;
            c_WNT:   nxt = taken ? c_WT  : c_SNT;
            c_WT:    nxt = taken ? c_ST  : c_WNT;
            c_ST:    nxt = taken ? c_ST  : c_WT;
            default: nxt = cur;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/global_branch_predictor.sv
// +----------------------------------------------------------------------+
// | Module   : global_branch_predictor                                   |
// | Brief    : Gshare predictor: PHT of 2-bit counters indexed by PC^GHR |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module global_branch_predictor
    import global_branch_predictor_pkg::*;
#(
    parameter int IDX_BITS  = 8,
    parameter int HIST_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         pc_F,
    output logic                predict_F,
    output logic [IDX_BITS-1:0] pred_idx_F,
    output logic                ready,
    input  logic                upd_valid_D,
    input  logic                upd_taken_D,
    input  logic                upd_pred_D,
    input  logic [IDX_BITS-1:0] upd_idx_D,
    output logic                mispredict_D,
    output logic [31:0]         branch_count,
    output logic [31:0]         mispred_count
);

    localparam int                c_ENTRIES   = 2 ** IDX_BITS;
    localparam logic [IDX_BITS-1:0] c_WALK_LAST = '1;

    logic [1:0]           r_pht [c_ENTRIES];
    logic [HIST_BITS-1:0] r_ghr;
    logic [IDX_BITS-1:0]  r_walk;
    logic [31:0]          r_branch_count;
    logic [31:0]          r_mispred_count;
    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_walk_we;
    logic                 w_upd_en;
    logic                 w_ready;
    logic                 w_mispredict;
    logic [1:0]           w_cnt_nxt;

    // Only the word-aligned index bits of the PC take part in the lookup.
    wire w_unused_pc = &{1'b0, pc_F[31:IDX_BITS+2], pc_F[1:0]};

    assign pred_idx_F    = pc_F[IDX_BITS+1:2] ^ IDX_BITS'(r_ghr);
    assign predict_F     = w_ready & r_pht[pred_idx_F][1];
    assign ready         = w_ready;
    assign mispredict_D  = w_mispredict;
    assign branch_count  = r_branch_count;
    assign mispred_count = r_mispred_count;

    sat_counter2 u_sat_counter2 (
        .cur   (r_pht[upd_idx_D]),
        .taken (upd_taken_D),
        .nxt   (w_cnt_nxt)
    );

    always_ff @(posedge clk) begin
        if (!reset) r_state <= INIT;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ready      = 1'b0;
        w_walk_we    = 1'b0;
        w_upd_en     = 1'b0;
        w_mispredict = 1'b0;
        case (r_state)
            INIT: begin
                w_walk_we = 1'b1;
                if (r_walk == c_WALK_LAST) w_state_nxt = RUN;
            end
            RUN: begin
                w_ready      = 1'b1;
                w_upd_en     = upd_valid_D;
                w_mispredict = upd_valid_D & (upd_taken_D != upd_pred_D);
            end
            default: w_state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_walk          <= '0;
            r_ghr           <= '0;
            r_branch_count  <= '0;
            r_mispred_count <= '0;
        end else begin
            if (w_walk_we) r_walk <= r_walk + 1'b1;
            if (w_upd_en) begin
                r_ghr          <= {r_ghr[HIST_BITS-2:0], upd_taken_D};
                r_branch_count <= r_branch_count + 32'd1;
                if (w_mispredict) r_mispred_count <= r_mispred_count + 32'd1;
            end
        end
    end

    // PHT has no reset of its own; the INIT walk rewrites every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (w_walk_we)     r_pht[r_walk]    <= c_WNT;
            else if (w_upd_en) r_pht[upd_idx_D] <= w_cnt_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_global_branch_predictor.sv
// +----------------------------------------------------------------------+
// | Module   : tb_global_branch_predictor                                |
// | Brief    : Directed self-checking bench for global_branch_predictor  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_global_branch_predictor;

    localparam int IDX_BITS  = 4;
    localparam int HIST_BITS = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [31:0]         pc_F;
    logic                predict_F;
    logic [IDX_BITS-1:0] pred_idx_F;
    logic                ready;
    logic                upd_valid_D;
    logic                upd_taken_D;
    logic                upd_pred_D;
    logic [IDX_BITS-1:0] upd_idx_D;
    logic                mispredict_D;
    logic [31:0]         branch_count;
    logic [31:0]         mispred_count;

    int checks = 0;
    int errors = 0;

    global_branch_predictor #(
        .IDX_BITS  (IDX_BITS),
        .HIST_BITS (HIST_BITS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_F          (pc_F),
        .predict_F     (predict_F),
        .pred_idx_F    (pred_idx_F),
        .ready         (ready),
        .upd_valid_D   (upd_valid_D),
        .upd_taken_D   (upd_taken_D),
        .upd_pred_D    (upd_pred_D),
        .upd_idx_D     (upd_idx_D),
        .mispredict_D  (mispredict_D),
        .branch_count  (branch_count),
        .mispred_count (mispred_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic v, input logic [3:0] idx, input logic tk, input logic pr);
        upd_valid_D = v;
        upd_idx_D   = idx;
        upd_taken_D = tk;
        upd_pred_D  = pr;
    endtask

    initial begin
        reset = 1'b0;
        pc_F  = 32'h0;
        upd(1'b0, 4'd0, 1'b0, 1'b0);

        // 1. reset and init walk
        repeat (3) step();
        pc_F = 32'h14;
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_bcnt", branch_count, 0);
        chk("rst_mcnt", mispred_count, 0);
        chk("rst_pred", predict_F, 0);
        chk("rst_idx", pred_idx_F, 5);
        chk("rst_misp", mispredict_D, 0);
        reset = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("init_ready", ready, (k == 16) ? 1 : 0);
            if (k < 16) begin
                pc_F = 32'(k * 4);
                #1;
                chk("init_pred", predict_F, 0);
                chk("init_bcnt", branch_count, 0);
            end
        end

        // 2. train idx 3 taken, mispredicted
        upd(1'b1, 4'd3, 1'b1, 1'b0);
        #1;
        chk("tr_misp", mispredict_D, 1);
        step();
        upd(1'b0, 4'd0, 1'b0, 1'b0);
        pc_F = 32'h8;
        #1;
        chk("tr_bcnt", branch_count, 1);
        chk("tr_mcnt", mispred_count, 1);
        chk("tr_idx", pred_idx_F, 3);
        chk("tr_pred", predict_F, 1);
        pc_F = 32'h0;
        #1;
        chk("tr_ghr", pred_idx_F, 1);

        // 3. saturation on idx 5
        upd(1'b1, 4'd5, 1'b1, 1'b1);
        repeat (4) step();
        upd(1'b0, 4'd0, 1'b0, 1'b0);
        pc_F = 32'h28;
        #1;
        chk("sat_idx_st", pred_idx_F, 5);
        chk("sat_pred_st", predict_F, 1);
        chk("sat_bcnt5", branch_count, 5);
        chk("sat_mcnt1", mispred_count, 1);
        upd(1'b1, 4'd5, 1'b0, 1'b1);
        #1;
        chk("sat_misp_nt", mispredict_D, 1);
        step();
        upd(1'b0, 4'd0, 1'b0, 1'b0);
        pc_F = 32'h2C;
        #1;
        chk("sat_idx_wt", pred_idx_F, 5);
        chk("sat_pred_wt", predict_F, 1);
        upd(1'b1, 4'd5, 1'b0, 1'b0);
        repeat (2) step();
        upd(1'b0, 4'd0, 1'b0, 1'b0);
        pc_F = 32'h34;
        #1;
        chk("sat_idx_snt", pred_idx_F, 5);
        chk("sat_pred_snt", predict_F, 0);
        chk("sat_bcnt8", branch_count, 8);
        chk("sat_mcnt2", mispred_count, 2);

        // 4. read-during-write on idx 7
        pc_F = 32'h3C;
        upd(1'b1, 4'd7, 1'b1, 1'b0);
        #1;
        chk("rdw_idx", pred_idx_F, 7);
        chk("rdw_pred_old", predict_F, 0);
        chk("rdw_misp", mispredict_D, 1);
        step();
        upd(1'b0, 4'd0, 1'b0, 1'b0);
        pc_F = 32'h18;
        #1;
        chk("rdw_idx_new", pred_idx_F, 7);
        chk("rdw_pred_new", predict_F, 1);

        // 5. correct prediction
        upd(1'b1, 4'd7, 1'b1, 1'b1);
        #1;
        chk("cp_misp", mispredict_D, 0);
        step();
        upd(1'b0, 4'd0, 1'b0, 1'b0);
        #1;
        chk("cp_bcnt", branch_count, 10);
        chk("cp_mcnt", mispred_count, 3);

        // 6. reset mid-run
        reset = 1'b0;
        step();
        reset = 1'b1;
        pc_F  = 32'h0;
        #1;
        chk("mr_ready", ready, 0);
        chk("mr_bcnt", branch_count, 0);
        chk("mr_mcnt", mispred_count, 0);
        chk("mr_ghr", pred_idx_F, 0);
        for (int k = 1; k <= 16; k++) begin
            if (k >= 10 && k <= 12) begin
                upd(1'b1, 4'd7, 1'b1, 1'b0);
                #1;
                chk("mr_init_misp", mispredict_D, 0);
            end
            step();
            upd(1'b0, 4'd0, 1'b0, 1'b0);
            chk("mr_init_ready", ready, (k == 16) ? 1 : 0);
        end
        chk("mr_bcnt_end", branch_count, 0);
        chk("mr_mcnt_end", mispred_count, 0);
        for (int i = 0; i < 16; i++) begin
            pc_F = 32'(i * 4);
            #1;
            chk("mr_idx", pred_idx_F, i);
            chk("mr_pred", predict_F, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
